// File: rtl/data_pipe_pkg.sv
// Shared constants and helpers for the data_pipe elastic pipeline.
package data_pipe_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/data_pipe_stage.sv
// One elastic register slot: holds a valid/data pair and loads from upstream when
// it is empty or its downstream neighbour can take its current beat.
module data_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              dn_ready,
  output logic              rdy_out,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  assign rdy_out = !valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy_out) begin
      valid <= up_valid;
      // data only moves with a real beat so an empty slot keeps its last value
      if (up_valid) data <= up_data;
    end
  end
endmodule

// File: rtl/data_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline with flush; DATA_PIPE_COUNT_EN adds
// the occupancy port and counter.
module data_pipe
  import data_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef DATA_PIPE_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] occupancy
`endif
);
  logic [DEPTH:0]                  rdy;
  logic [DEPTH-1:0]                vld;
  logic [DEPTH-1:0][DATA_W-1:0]    dat;
  logic [DEPTH-1:0]                up_vld;
  logic [DEPTH-1:0][DATA_W-1:0]    up_dat;
  logic                            accept;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] && !rst && !flush;
  assign accept     = in_valid && in_ready;

  // Outputs forced quiet while reset is asserted, before the registers clear.
  assign out_valid = vld[DEPTH-1] && !rst;
  assign out_data  = rst ? '0 : dat[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_vld[g] = accept;
      assign up_dat[g] = in_data;
    end else begin : g_body
      assign up_vld[g] = vld[g-1];
      assign up_dat[g] = dat[g-1];
    end

    data_pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_vld[g]),
      .up_data  (up_dat[g]),
      .dn_ready (rdy[g+1]),
      .rdy_out  (rdy[g]),
      .valid    (vld[g]),
      .data     (dat[g])
    );
  end

`ifdef DATA_PIPE_COUNT_EN
  localparam int CW = cnt_w(DEPTH);
  logic          xfer;
  logic [CW-1:0] cnt;

  assign xfer      = out_valid && out_ready;
  assign occupancy = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush)        cnt <= '0;
    else if (accept && !xfer) cnt <= cnt + CW'(1);
    else if (!accept && xfer) cnt <= cnt - CW'(1);
  end
`endif
endmodule

// File: tb/tb_data_pipe.sv
// Scoreboard bench for data_pipe: FIFO reference model in a queue, separate monitor.
module tb_data_pipe;
  import data_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  logic       d1_flush = 1'b0;
  logic       d1_in_valid = 1'b0;
  logic       d1_in_ready;
  logic [7:0] d1_in_data = 8'h00;
  logic       d1_out_valid;
  logic       d1_out_ready = 1'b0;
  logic [7:0] d1_out_data;
`ifdef DATA_PIPE_COUNT_EN
  logic [cnt_w(2)-1:0] occupancy;
  logic [cnt_w(1)-1:0] d1_occupancy;
`endif

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;
  logic last_acc;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  data_pipe #(.DATA_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef DATA_PIPE_COUNT_EN
    , .occupancy(occupancy)
`endif
  );

  data_pipe #(.DATA_W(8), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(d1_flush),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data)
`ifdef DATA_PIPE_COUNT_EN
    , .occupancy(d1_occupancy)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: sample the handshake mid-cycle, record accepted beat after the edge.
  task automatic tick();
    @(negedge clk);
    last_acc = in_valid && in_ready;
    @(posedge clk);
    if (last_acc) exp_q.push_back(in_data);
    #1;
  endtask

  // Monitor: occupancy equals beats in flight; outputs must pop in FIFO order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
`ifdef DATA_PIPE_COUNT_EN
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
`endif
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
        else if (out_ready) begin
          chk("out_data_order", 32'(out_data), 32'(exp_q.pop_front()));
          pop_cnt++;
        end
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    int tries;
    @(posedge clk); #1;
    // reset held three cycles with a beat offered
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
`ifdef DATA_PIPE_COUNT_EN
      if (i > 0) chk("rst_occupancy", 32'(occupancy), 32'd0);
`endif
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    #2;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    tick();

    // streaming with latency and no gaps
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 8'(k * 25);
      #2;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), 32'(k >= 2));
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("stream_tail_valid", 32'(out_valid), 32'(k < 2));
      tick();
    end

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5; tick();
    in_data = 8'h5A; tick();
    in_data = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'hA5);
`ifdef DATA_PIPE_COUNT_EN
      chk("bp_occupancy", 32'(occupancy), 32'd2);
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #2; chk("bp_first", 32'(out_data), 32'hA5); tick();
    #2; chk("bp_second", 32'(out_data), 32'h5A); tick();
    tick();

    // flush with two beats in flight and a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h77; flush = 1'b1;
    #2; chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef DATA_PIPE_COUNT_EN
    chk("flush_occupancy", 32'(occupancy), 32'd0);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2; chk("flush_no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    // exhaustive values under random handshakes
    pop_cnt = 0;
    for (int v = 0; v < 256; v++) begin
      in_data = 8'(v);
      tries = 0;
      do begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        tick();
        tries++;
      end while (!last_acc && tries < 200);
      if (!last_acc) chk("exh_accept_timeout", 32'(v), 32'hFFFF_FFFF);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tries = 0;
    while (exp_q.size() != 0 && tries < 50) begin
      tick(); tries++;
    end
    tick();
    chk("exh_pop_count", 32'(pop_cnt), 32'd256);
    chk("exh_drained_valid", 32'(out_valid), 32'd0);

    // DEPTH=1: full stage streaming one beat per cycle
    d1_out_ready = 1'b1; d1_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d1_in_data = 8'(i + 8'h40);
      #2;
      chk("d1_in_ready", 32'(d1_in_ready), 32'd1);
      if (i >= 1) begin
        chk("d1_out_valid", 32'(d1_out_valid), 32'd1);
        chk("d1_out_data", 32'(d1_out_data), 32'(i - 1 + 8'h40));
`ifdef DATA_PIPE_COUNT_EN
        chk("d1_occupancy", 32'(d1_occupancy), 32'd1);
`endif
      end
      @(posedge clk); #1;
    end
    d1_in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
